// File: rtl/serial_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Package  : serial_receiver_pkg
// Brief    : Shared word geometry and receive-FSM state encoding for the
//            serial link (transmit and receive sides).
// Revision : 1.0 - initial release
// ============================================================================
package serial_receiver_pkg;

    localparam int c_data_width = 8;
    localparam int c_addr_width = 4;

    localparam int             c_state_w   = 2;
    localparam logic [1:0]     c_st_idle   = 2'd0;
    localparam logic [1:0]     c_st_shift  = 2'd1;
    localparam logic [1:0]     c_st_write  = 2'd2;
    localparam logic [1:0]     c_st_ack    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rx_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : rx_shift_reg
// Brief    : MSB-first serial-to-parallel shift register with bit counter and
//            terminal-count flag for the last bit of a word.
// Revision : 1.0 - initial release
// ============================================================================
module rx_shift_reg
    import serial_receiver_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic                  clear,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] word,
    output logic [3:0]            Q,
    output logic                  tc_bit
);

    logic [DATA_WIDTH-1:0] r_word;
    logic [3:0]            r_q;
    logic                  w_tc;

    assign w_tc = shift_en && (r_q == 4'(DATA_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_q    <= '0;
        end else if (clear) begin
            r_word <= '0;
            r_q    <= '0;
        end else if (shift_en) begin
            r_word <= {r_word[DATA_WIDTH-2:0], serial_in};
            r_q    <= w_tc ? 4'd0 : r_q + 4'd1;
        end
    end

    assign word   = r_word;
    assign Q      = r_q;
    assign tc_bit = w_tc;

endmodule
`default_nettype wire

// File: rtl/serial_receiver.sv
`default_nettype none
// ============================================================================
// Module   : serial_receiver
// Brief    : Receives MSB-first serial words, writes each into RAM at an
//            auto-incrementing address and acknowledges the sender.
// Revision : 1.0 - initial release
// ============================================================================
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int ADDR_WIDTH = c_addr_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  transmit,
    input  logic                  transmit_data,
    output logic                  shift_enable,
    output logic [3:0]            Q,
    output logic                  tc_bit,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  received_n,
    output logic                  frame_err,
    output logic                  done
);

    logic [c_state_w-1:0]  r_state;
    logic [c_state_w-1:0]  w_next_state;
    logic                  w_shift_en;
    logic                  w_abort;
    logic                  w_we;
    logic                  w_ack;
    logic                  w_tc;
    logic [DATA_WIDTH-1:0] w_word;
    logic [3:0]            w_q;
    logic [DATA_WIDTH-1:0] r_ram_data;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic                  r_done;

    rx_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift_reg (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (w_shift_en),
        .clear     (w_abort),
        .serial_in (transmit_data),
        .word      (w_word),
        .Q         (w_q),
        .tc_bit    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_abort      = 1'b0;
        w_we         = 1'b0;
        w_ack        = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (transmit) begin
                    w_shift_en   = 1'b1;
                    w_next_state = c_st_shift;
                end
            end
            c_st_shift: begin
                if (transmit) begin
                    w_shift_en = 1'b1;
                    if (w_tc) begin
                        w_next_state = c_st_write;
                    end
                end else begin
                    w_abort      = 1'b1;
                    w_next_state = c_st_idle;
                end
            end
            c_st_write: begin
                w_we         = 1'b1;
                w_next_state = c_st_ack;
            end
            c_st_ack: begin
                w_ack        = 1'b1;
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Word, address and sticky wrap flag; done rises on the write to the top address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_data <= '0;
            r_ram_addr <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_we) begin
                r_ram_data <= w_word;
                if (&r_ram_addr) begin
                    r_done <= 1'b1;
                end
            end
            if (w_ack) begin
                r_ram_addr <= r_ram_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // Strobes are masked by rst so a reset cycle never produces a partial transaction.
    assign shift_enable = w_shift_en & ~rst;
    assign tc_bit       = w_tc & ~rst;
    assign write_enable = w_we & ~rst;
    assign frame_err    = w_abort & ~rst;
    assign received_n   = ~w_ack | rst;
    assign Q            = w_q;
    assign ram_addr     = r_ram_addr;
    assign ram_data     = w_we ? w_word : r_ram_data;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_receiver
// Brief    : Directed and randomized bench for serial_receiver with a
//            word-level reference model (expected address, data and done).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       transmit;
    logic       transmit_data;
    logic       shift_enable;
    logic [3:0] Q;
    logic       tc_bit;
    logic       write_enable;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       received_n;
    logic       frame_err;
    logic       done;

    int checks = 0;
    int errors = 0;

    int model_addr = 0;
    bit model_done = 1'b0;

    serial_receiver dut (
        .clk           (clk),
        .rst           (rst),
        .transmit      (transmit),
        .transmit_data (transmit_data),
        .shift_enable  (shift_enable),
        .Q             (Q),
        .tc_bit        (tc_bit),
        .write_enable  (write_enable),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .received_n    (received_n),
        .frame_err     (frame_err),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        transmit      = 1'($urandom_range(0, 1));
        transmit_data = 1'($urandom_range(0, 1));
        sample();
        check("rst_cycle_shift_enable", shift_enable, 0);
        check("rst_cycle_write_enable", write_enable, 0);
        check("rst_cycle_received_n", received_n, 1);
        check("rst_cycle_frame_err", frame_err, 0);
        check("rst_cycle_tc_bit", tc_bit, 0);
        step();
        rst        = 1'b0;
        transmit   = 1'b0;
        model_addr = 0;
        model_done = 1'b0;
        sample();
        check("reset_Q", Q, 0);
        check("reset_ram_addr", ram_addr, 0);
        check("reset_ram_data", ram_data, 0);
        check("reset_done", done, 0);
        check("reset_write_enable", write_enable, 0);
        check("reset_received_n", received_n, 1);
        check("reset_frame_err", frame_err, 0);
        check("reset_shift_enable", shift_enable, 0);
        step();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            transmit      = 1'b0;
            transmit_data = 1'($urandom_range(0, 1));
            sample();
            check("idle_shift_enable", shift_enable, 0);
            check("idle_write_enable", write_enable, 0);
            check("idle_received_n", received_n, 1);
            check("idle_frame_err", frame_err, 0);
            step();
        end
    endtask

    // rst_at: 0 none, 1 reset right after a partial word, 2 reset in the ack cycle
    task automatic send_word(input logic [7:0] w, input int nbits, input bit hold, input int rst_at);
        for (int i = 0; i < nbits; i++) begin
            transmit      = 1'b1;
            transmit_data = w[7-i];
            sample();
            check("bit_shift_enable", shift_enable, 1);
            check("bit_Q", Q, i);
            check("bit_tc_bit", tc_bit, (i == 7) ? 1 : 0);
            check("bit_write_enable", write_enable, 0);
            check("bit_received_n", received_n, 1);
            step();
        end
        if (nbits < 8) begin
            if (rst_at == 1) begin
                do_reset();
                return;
            end
            transmit      = 1'b0;
            transmit_data = 1'($urandom_range(0, 1));
            sample();
            check("abort_frame_err", frame_err, 1);
            check("abort_shift_enable", shift_enable, 0);
            check("abort_write_enable", write_enable, 0);
            step();
            sample();
            check("after_abort_frame_err", frame_err, 0);
            check("after_abort_Q", Q, 0);
            check("after_abort_ram_addr", ram_addr, model_addr);
            check("after_abort_write_enable", write_enable, 0);
            step();
            return;
        end
        transmit      = hold;
        transmit_data = 1'($urandom_range(0, 1));
        sample();
        check("write_write_enable", write_enable, 1);
        check("write_ram_data", ram_data, w);
        check("write_ram_addr", ram_addr, model_addr);
        check("write_shift_enable", shift_enable, 0);
        check("write_received_n", received_n, 1);
        check("write_Q", Q, 0);
        step();
        if (rst_at == 2) begin
            do_reset();
            return;
        end
        transmit      = hold;
        transmit_data = 1'($urandom_range(0, 1));
        sample();
        check("ack_received_n", received_n, 0);
        check("ack_write_enable", write_enable, 0);
        check("ack_shift_enable", shift_enable, 0);
        step();
        if (model_addr == 15) model_done = 1'b1;
        model_addr = (model_addr + 1) % 16;
        transmit   = 1'b0;
        sample();
        check("post_ram_addr", ram_addr, model_addr);
        check("post_done", done, model_done);
        check("post_ram_data_hold", ram_data, w);
        check("post_received_n", received_n, 1);
        step();
    endtask

    initial begin
        rst           = 1'b1;
        transmit      = 1'b0;
        transmit_data = 1'b0;

        do_reset();

        // single word 0xA5
        send_word(8'hA5, 8, 1'b0, 0);
        check("a5_addr_after", ram_addr, 1);

        // fill all 16 addresses and wrap
        do_reset();
        for (int k = 0; k < 16; k++) begin
            send_word(8'(k), 8, 1'b0, 0);
        end
        check("fill_done", done, 1);
        check("fill_wrap_addr", ram_addr, 0);

        // aborted word, then the retry lands at the same address
        send_word(8'($urandom), 5, 1'b0, 0);
        send_word(8'h3C, 8, 1'b0, 0);

        // transmit held high through write/ack
        send_word(8'($urandom), 8, 1'b1, 0);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] w;
            bit         drop;
            w    = 8'($urandom);
            drop = ($urandom_range(0, 3) == 0);
            send_word(w, drop ? int'($urandom_range(1, 7)) : 8, 1'($urandom_range(0, 1)), 0);
            idle_cycles(int'($urandom_range(0, 2)));
        end
        check("random_done_sticky", done, 1);

        // reset in the middle of a word
        send_word(8'($urandom), 4, 1'b0, 1);
        check("midword_rst_done", done, 0);

        // reset in the ack cycle of the third word
        send_word(8'($urandom), 8, 1'b0, 0);
        send_word(8'($urandom), 8, 1'b0, 0);
        send_word(8'($urandom), 8, 1'b0, 2);
        check("ack_rst_addr", ram_addr, 0);
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameters: DATA_WIDTH, default 8, bits per word; ADDR_WIDTH, default 4, RAM address width (2**ADDR_WIDTH words).
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 transmit  input  1  frame-valid from upstream serializer; high while serial bits are on transmit_data.
REQ-005 transmit_data  input  1  serial data bit, MSB first, one bit per clk while transmit=1.
REQ-006 shift_enable  output  1  high in any cycle a bit is sampled into the shift register.
REQ-007 Q  output  4  bit counter, bits of the current word already sampled.
REQ-008 tc_bit  output  1  terminal count; high in the cycle the last bit (bit index 0) is sampled.
REQ-009 write_enable  output  1  one-cycle RAM write strobe.
REQ-010 ram_addr  output  ADDR_WIDTH  RAM write address.
REQ-011 ram_data  output  DATA_WIDTH  assembled word, valid while write_enable=1.
REQ-012 received_n  output  1  active-low one-cycle word-accepted pulse back to the sender.
REQ-013 frame_err  output  1  one-cycle pulse on aborted word.
REQ-014 done  output  1  sticky; set when the word at address 2**ADDR_WIDTH-1 is written.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, WRITE, ACK.
REQ-016 IDLE: transmit=1 -> sample bit into shift register LSB (shift left), Q<=1, shift_enable=1, go to SHIFT; else stay.
REQ-017 SHIFT: transmit=1 -> shift in bit, Q<=Q+1, shift_enable=1; tc_bit=1 when Q=DATA_WIDTH-1, then Q<=0, go to WRITE.
REQ-018 SHIFT with transmit=0 before tc_bit -> discard partial word, Q<=0, frame_err=1 for one cycle, go to IDLE; ram_addr unchanged.
REQ-019 WRITE: write_enable=1 for exactly one cycle, ram_data=assembled word, ram_addr=current address; go to ACK.
REQ-020 ACK: received_n=0 for exactly one cycle; ram_addr<=ram_addr+1 modulo 2**ADDR_WIDTH; go to IDLE.
REQ-021 Latency: last bit sampled in cycle N -> write_enable in N+1 -> received_n low in N+2 -> next word's first bit accepted no earlier than N+3.
REQ-022 transmit and transmit_data SHALL be ignored in WRITE and ACK; sender waits for received_n before the next word.
REQ-023 Address wrap: after writing address 2**ADDR_WIDTH-1, ram_addr wraps to 0, done<=1; receiving continues and overwrites from 0.
REQ-024 done SHALL remain 1 until rst.
REQ-025 shift_enable, tc_bit, write_enable, frame_err SHALL be 0 and received_n 1 in all cycles not named above.
REQ-026 ram_data SHALL hold the last assembled word between writes.

Reset
REQ-027 rst=1 at a clock edge SHALL force: state IDLE, Q=0, shift register=0, ram_data=0, ram_addr=0, done=0, write_enable=0, shift_enable=0, tc_bit=0, frame_err=0, received_n=1.
REQ-028 rst in SHIFT/WRITE/ACK SHALL abandon the word with no write, no received_n pulse, no frame_err.
REQ-029 rst has priority over every other input in the same cycle.

Structure
REQ-030 FSM state encoding and default DATA_WIDTH/ADDR_WIDTH constants SHALL live in the shared project package, shared with the transmit side.
REQ-031 The shift register with bit counter SHALL be one sub-module, rx_shift_reg (outputs word, Q, tc_bit); FSM and address counter stay in serial_receiver.

Verification
REQ-032 After rst, transmit=1 for 8 cycles sending 8'hA5 MSB first -> tc_bit on 8th bit, next cycle write_enable=1, ram_addr=0, ram_data=8'hA5, then received_n=0, ram_addr=1.
REQ-033 Send 16 words 8'h00..8'h0F each after received_n -> writes at addresses 0..15 with matching data, done=1 after 16th write, ram_addr=0.
REQ-034 Drop transmit after 5 bits -> frame_err one-cycle pulse, no write_enable, Q=0, ram_addr unchanged; next full word 8'h3C written at the same address.
REQ-035 Hold transmit=1 through WRITE/ACK with toggling data -> no sampling, no shift_enable in those cycles; data written equals the first 8 bits only.
REQ-036 Assert rst after 4 bits of a word and after write_enable of word 3 -> all outputs at reset values next cycle, no received_n pulse, done=0, ram_addr=0.
